// File: rtl/pit_bus_interface_if.sv
// CPU-side bus of the PIT register interface: active-low strobes, register
// select and split read/write data with an output-enable qualifier.
interface pit_bus_interface_if;
  logic       CS;
  logic       RD;
  logic       WR;
  logic [1:0] A;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic       D_oe;

  modport master (output CS, RD, WR, A, D_in, input D_out, D_oe);
  modport slave  (input CS, RD, WR, A, D_in, output D_out, D_oe);
endinterface

// File: rtl/pit_bus_interface.sv
// CPU register interface of a three-counter PIT: decodes control words, steers
// count-register byte writes, and serves latched or live count/status reads.
module pit_bus_interface (
  input  logic                      clk,
  input  logic                      rst_n,
  pit_bus_interface_if.slave        bus,
  input  logic [15:0]               count0,
  input  logic [15:0]               count1,
  input  logic [15:0]               count2,
  input  logic [7:0]                status0,
  input  logic [7:0]                status1,
  input  logic [7:0]                status2,
  output logic [7:0]                control_word,
  output logic [2:0]                cw_wr,
  output logic [2:0]                cr_lsb_we,
  output logic [2:0]                cr_msb_we,
  output logic [7:0]                cr_data,
  output logic [2:0]                count_loaded
);

  typedef enum logic {ST_IDLE, ST_READ} state_t;

  state_t          state_q, state_d;
  logic [1:0]      rd_sel_q, rd_sel_d;
  logic            wr_prev_q, wr_prev_d;
  logic            rd_prev_q, rd_prev_d;
  logic            cs_prev_q, cs_prev_d;
  logic            wr_armed_q, wr_armed_d;
  logic [1:0]      a_prev_q, a_prev_d;
  logic [7:0]      d_prev_q, d_prev_d;
  logic [2:0][1:0] rw_q, rw_d;
  logic [2:0]      wr_ptr_q, wr_ptr_d;
  logic [2:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      ol_valid_q, ol_valid_d;
  logic [2:0][15:0] ol_q, ol_d;
  logic [2:0]      st_valid_q, st_valid_d;
  logic [2:0][7:0] st_q, st_d;
  logic [7:0]      control_word_q, control_word_d;
  logic [2:0]      cw_wr_q, cw_wr_d;
  logic [2:0]      cr_lsb_we_q, cr_lsb_we_d;
  logic [2:0]      cr_msb_we_q, cr_msb_we_d;
  logic [7:0]      cr_data_q, cr_data_d;
  logic [2:0]      count_loaded_q, count_loaded_d;

  logic [2:0][15:0] count_in;
  logic [2:0][7:0]  status_in;
  logic             write_ev;
  logic             read_start;
  logic             read_end;
  logic [15:0]      rd_word;
  logic             rd_msb;
  logic [7:0]       rd_byte;

  assign count_in  = {count2, count1, count0};
  assign status_in = {status2, status1, status0};

  // A write only counts if WR was seen falling after reset; a strobe already
  // low when reset released must not complete as a write.
  assign write_ev   = bus.WR && !wr_prev_q && wr_armed_q && !cs_prev_q && rd_prev_q;
  assign read_start = (state_q == ST_IDLE) && rd_prev_q && !bus.RD && !bus.CS && bus.WR;
  assign read_end   = (state_q == ST_READ) && bus.RD;

  always_comb begin
    rd_word = 16'h0000;
    rd_msb  = 1'b0;
    rd_byte = 8'h00;
    if (rd_sel_q != 2'd3) begin
      rd_word = ol_valid_q[rd_sel_q] ? ol_q[rd_sel_q] : count_in[rd_sel_q];
      case (rw_q[rd_sel_q])
        2'b10:   rd_msb = 1'b1;
        2'b11:   rd_msb = rd_ptr_q[rd_sel_q];
        default: rd_msb = 1'b0;
      endcase
      rd_byte = st_valid_q[rd_sel_q] ? st_q[rd_sel_q]
              : (rd_msb ? rd_word[15:8] : rd_word[7:0]);
    end
  end

  assign bus.D_oe  = (state_q == ST_READ);
  assign bus.D_out = bus.D_oe ? rd_byte : 8'h00;

  always_comb begin
    state_d        = state_q;
    rd_sel_d       = rd_sel_q;
    wr_prev_d      = bus.WR;
    rd_prev_d      = bus.RD;
    cs_prev_d      = bus.CS;
    wr_armed_d     = !bus.WR && (wr_armed_q || wr_prev_q);
    a_prev_d       = bus.A;
    d_prev_d       = bus.D_in;
    rw_d           = rw_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    ol_valid_d     = ol_valid_q;
    ol_d           = ol_q;
    st_valid_d     = st_valid_q;
    st_d           = st_q;
    control_word_d = control_word_q;
    cw_wr_d        = 3'b000;
    cr_lsb_we_d    = 3'b000;
    cr_msb_we_d    = 3'b000;
    cr_data_d      = cr_data_q;
    count_loaded_d = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (read_start) begin
          state_d  = ST_READ;
          rd_sel_d = bus.A;
        end
      end
      ST_READ: begin
        if (read_end) begin
          state_d = ST_IDLE;
          if (rd_sel_q != 2'd3) begin
            if (st_valid_q[rd_sel_q]) begin
              st_valid_d[rd_sel_q] = 1'b0;
            end else begin
              if (rw_q[rd_sel_q] == 2'b11)
                rd_ptr_d[rd_sel_q] = !rd_ptr_q[rd_sel_q];
              if (ol_valid_q[rd_sel_q] && (rw_q[rd_sel_q] != 2'b11 || rd_ptr_q[rd_sel_q]))
                ol_valid_d[rd_sel_q] = 1'b0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (write_ev) begin
      if (a_prev_q == 2'd3) begin
        if (d_prev_q[7:6] == 2'b11) begin
          for (int i = 0; i < 3; i++) begin
            if (d_prev_q[i+1]) begin
              if (!d_prev_q[5] && !ol_valid_d[i]) begin
                ol_valid_d[i] = 1'b1;
                ol_d[i]       = count_in[i];
              end
              if (!d_prev_q[4] && !st_valid_d[i]) begin
                st_valid_d[i] = 1'b1;
                st_d[i]       = status_in[i];
              end
            end
          end
        end else if (d_prev_q[5:4] == 2'b00) begin
          // Latching never touches the read pointer, so a latch that lands
          // between the two bytes of a live read continues at the MSB.
          if (!ol_valid_d[d_prev_q[7:6]]) begin
            ol_valid_d[d_prev_q[7:6]] = 1'b1;
            ol_d[d_prev_q[7:6]]       = count_in[d_prev_q[7:6]];
          end
        end else begin
          rw_d[d_prev_q[7:6]]       = d_prev_q[5:4];
          control_word_d            = d_prev_q;
          cw_wr_d[d_prev_q[7:6]]    = 1'b1;
          wr_ptr_d[d_prev_q[7:6]]   = 1'b0;
          rd_ptr_d[d_prev_q[7:6]]   = 1'b0;
          ol_valid_d[d_prev_q[7:6]] = 1'b0;
          st_valid_d[d_prev_q[7:6]] = 1'b0;
        end
      end else begin
        cr_data_d = d_prev_q;
        case (rw_q[a_prev_q])
          2'b01: begin
            cr_lsb_we_d[a_prev_q]    = 1'b1;
            count_loaded_d[a_prev_q] = 1'b1;
          end
          2'b10: begin
            cr_msb_we_d[a_prev_q]    = 1'b1;
            count_loaded_d[a_prev_q] = 1'b1;
          end
          2'b11: begin
            if (!wr_ptr_q[a_prev_q]) begin
              cr_lsb_we_d[a_prev_q] = 1'b1;
              wr_ptr_d[a_prev_q]    = 1'b1;
            end else begin
              cr_msb_we_d[a_prev_q]    = 1'b1;
              count_loaded_d[a_prev_q] = 1'b1;
              wr_ptr_d[a_prev_q]       = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Strobe history resets to the "already low" view so that an access in
  // flight when reset hits is abandoned rather than completed on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rd_sel_q       <= 2'd0;
      wr_prev_q      <= 1'b0;
      rd_prev_q      <= 1'b0;
      cs_prev_q      <= 1'b1;
      wr_armed_q     <= 1'b0;
      a_prev_q       <= 2'd0;
      d_prev_q       <= 8'h00;
      rw_q           <= {3{2'b01}};
      wr_ptr_q       <= 3'b000;
      rd_ptr_q       <= 3'b000;
      ol_valid_q     <= 3'b000;
      ol_q           <= '0;
      st_valid_q     <= 3'b000;
      st_q           <= '0;
      control_word_q <= 8'h00;
      cw_wr_q        <= 3'b000;
      cr_lsb_we_q    <= 3'b000;
      cr_msb_we_q    <= 3'b000;
      cr_data_q      <= 8'h00;
      count_loaded_q <= 3'b000;
    end else begin
      state_q        <= state_d;
      rd_sel_q       <= rd_sel_d;
      wr_prev_q      <= wr_prev_d;
      rd_prev_q      <= rd_prev_d;
      cs_prev_q      <= cs_prev_d;
      wr_armed_q     <= wr_armed_d;
      a_prev_q       <= a_prev_d;
      d_prev_q       <= d_prev_d;
      rw_q           <= rw_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      ol_valid_q     <= ol_valid_d;
      ol_q           <= ol_d;
      st_valid_q     <= st_valid_d;
      st_q           <= st_d;
      control_word_q <= control_word_d;
      cw_wr_q        <= cw_wr_d;
      cr_lsb_we_q    <= cr_lsb_we_d;
      cr_msb_we_q    <= cr_msb_we_d;
      cr_data_q      <= cr_data_d;
      count_loaded_q <= count_loaded_d;
    end
  end

  assign control_word = control_word_q;
  assign cw_wr        = cw_wr_q;
  assign cr_lsb_we    = cr_lsb_we_q;
  assign cr_msb_we    = cr_msb_we_q;
  assign cr_data      = cr_data_q;
  assign count_loaded = count_loaded_q;

endmodule

// File: doc/pit_bus_interface.md
PIT_BUS_INTERFACE -- requirements
Module: pit_bus_interface

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 CS, RD, WR  in  1 each  active-low CPU strobes, sampled on clk.
REQ-004 A  in  2  register select: 0..2 = counter 0..2, 3 = control word.
REQ-005 D_in  in  8  CPU write data.
REQ-006 D_out  out  8  CPU read data.
REQ-007 D_oe  out  1  high while a read is driven.
REQ-008 count0, count1, count2  in  16 each  live counter values.
REQ-009 status0, status1, status2  in  8 each  live status bytes from the counter control logic.
REQ-010 control_word  out  8  last programming control word accepted.
REQ-011 cw_wr  out  3  one-cycle pulse per counter when that counter's control word is accepted.
REQ-012 cr_lsb_we, cr_msb_we  out  3 each  one-cycle count-register byte write enables per counter; data is on cr_data.
REQ-013 cr_data  out  8  byte being written to the count register.
REQ-014 count_loaded  out  3  one-cycle pulse per counter when a complete initial count is written.

Function
REQ-015 A write event SHALL be WR sampled 0 then 1 with CS=0 in the low cycle; A and D_in SHALL be taken from that last low cycle.
REQ-016 A read start SHALL be RD falling with CS=0; a read end SHALL be the following RD rising edge.
REQ-017 Write A=3, D[7:6]=0..2, D[5:4]!=00 (program): the block SHALL:
- store rw[1:0] = D[5:4] for the selected counter;
- drive control_word = D and pulse cw_wr[n];
- reset that counter's write and read byte pointers to LSB;
- clear its count and status latches.
REQ-018 Write A=3, D[5:4]=00 (counter latch): the block SHALL capture count_n into OL_n if OL_n is not already latched; otherwise the command SHALL be ignored.
REQ-019 Write A=3, D[7:6]=11 (read-back), for each n with D[n+1]=1:
- D[5]=0 latches count as in REQ-018;
- D[4]=0 latches status_n unless status is already latched.
REQ-020 Count write A=n: cr_data = D. The enables SHALL follow rw_n:
- rw=01: cr_lsb_we[n] and count_loaded[n] together;
- rw=10: cr_msb_we[n] and count_loaded[n] together;
- rw=11: first byte cr_lsb_we[n], second byte cr_msb_we[n] plus count_loaded[n]; the pointer toggles per byte.
REQ-021 All output pulses SHALL occur in the clock cycle after the write event.
REQ-022 Read A=n source priority SHALL be: latched status first; then OL_n if latched; else live count_n.
REQ-023 Read byte selection SHALL follow rw_n:
- rw=01: LSB;
- rw=10: MSB;
- rw=11: LSB then MSB, with the pointer toggling at read end.
REQ-024 The status latch SHALL clear after one status read completes.
REQ-025 The count latch SHALL clear when its last byte per rw_n has been read.
REQ-026 D_oe SHALL be 1 from the cycle after read start through the cycle of read end; D_out SHALL be 8'h00 when D_oe=0.
REQ-027 A read with A=3 SHALL drive 8'h00 and change no state.
REQ-028 A write or read with CS=1 SHALL change no state.
REQ-029 Concurrent RD=0 and WR=0 SHALL be ignored.
REQ-030 A latch command arriving mid-read of an unlatched rw=11 value SHALL capture the count without resetting the read pointer.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously set:
- rw_n = 01 for all counters;
- all byte pointers to LSB;
- all count and status latches cleared;
- control_word = 8'h00;
- all pulses, D_oe, and D_out = 0.
REQ-032 A reset asserted mid-access SHALL abort the access, with no pulse generated after release.

Verification
REQ-033 The bench SHALL cover at least these directed scenarios:
- Write A=3 D=8'h34, then A=0 D=8'hE8, then A=0 D=8'h03 -> cw_wr=001; cr_lsb_we[0] with 8'hE8; then cr_msb_we[0] and count_loaded[0] with 8'h03.
- Counter 1 rw=11, count1=16'h1234, latch cmd D=8'h40; count1 then changes to 16'h1000; two reads A=1 -> 8'h34 then 8'h12; a third read -> live LSB 8'h00.
- Read-back D=8'hC2 with status0=8'hB4 and count0=16'h0055, rw=01 -> first read 8'hB4, second read 8'h55.
- Second latch command before any read, count changed from 16'h0AAA to 16'h0BBB -> read returns 16'h0AAA bytes.
- rst_n pulsed low after only the LSB of an rw=11 write -> next A=0 write (rw now 01) pulses cr_lsb_we[0] and count_loaded[0].
- CS=1 write A=3 D=8'h34 -> no cw_wr and control_word unchanged.
